mac_seq_ctrl: RTL and testbench

//  Sequencer for the 4-lane uint8 x int8 MAC datapath in the coprocessor. Accepts a dot-product command
//  (beat count, initial accumulator, ReLU flag) and streams packed operand beats (4 activations + 4 weights)

---
 rtl/mac_seq_ctrl_pkg.sv | 19 +
 rtl/mac_seq_ctrl_if.sv | 36 +++
 rtl/mac_seq_ctrl_mac_8.sv | 32 +++
 rtl/mac_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the MAC sequencer and its datapath.
package mac_seq_ctrl_pkg;

  // Sequencer states: waiting for a command, streaming beats, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  localparam int MAC_LANES = 4;
  localparam int MAC_ACC_W = 32;

  // Extract byte lane k (bits [8k+7:8k]) from a packed 4-lane operand word.
  function automatic logic [7:0] lane_slice(input logic [31:0] word, input int unsigned k);
    return word[8*k +: 8];
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command, operand and result handshakes between the issue logic and the MAC sequencer.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 16
);
  // Command channel
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic [31:0]      cmd_acc_i;
  logic             cmd_relu_i;
  // Operand beat channel
  logic             op_valid_i;
  logic             op_ready_o;
  logic [31:0]      op_act_i;
  logic [31:0]      op_wgt_i;
  // Result channel
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_data_o;

  // Sequencer side
  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_acc_i, cmd_relu_i,
    input  op_valid_i, op_act_i, op_wgt_i,
    input  res_ready_i,
    output cmd_ready_o, op_ready_o, res_valid_o, res_data_o
  );

  // Issue/decode side
  modport master (
    output cmd_valid_i, cmd_len_i, cmd_acc_i, cmd_relu_i,
    output op_valid_i, op_act_i, op_wgt_i,
    output res_ready_i,
    input  cmd_ready_o, op_ready_o, res_valid_o, res_data_o
  );
endinterface

// File: rtl/mac_seq_ctrl_mac_8.sv
// Four-lane uint8 x int8 multiply-accumulate: sum_out = sum_in + sum(act_k * wgt_k), mod 2^32.
module mac_8
  import mac_seq_ctrl_pkg::*;
(
  input  logic [7:0]  in_i     [MAC_LANES],
  input  logic [7:0]  weight_i [MAC_LANES],
  input  logic [31:0] sum_in_i,
  output logic [31:0] sum_out_o
);

  logic signed [16:0] act_ext_s;
  logic signed [16:0] wgt_ext_s;
  logic signed [16:0] prod_s;
  logic [31:0]        sum_s;

  // Zero-extend activations, sign-extend weights, and add every lane product to the incoming sum.
  always_comb begin
    act_ext_s = 17'sd0;
    wgt_ext_s = 17'sd0;
    prod_s    = 17'sd0;
    sum_s     = sum_in_i;
    for (int k = 0; k < MAC_LANES; k++) begin
      act_ext_s = signed'({9'b0, in_i[k]});
      wgt_ext_s = signed'({{9{weight_i[k][7]}}, weight_i[k]});
      // Product range is [-32640, 32385], so the 17-bit result is exact.
      prod_s    = act_ext_s * wgt_ext_s;
      sum_s     = sum_s + {{15{prod_s[16]}}, prod_s};
    end
    sum_out_o = sum_s;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: takes a command, streams operand beats through mac_8 and returns the sum.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int ACC_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  mac_seq_ctrl_if.slave bus,
  output logic          busy_o
);

  // The datapath is hard-wired to a 32-bit accumulator.
  if (ACC_W != MAC_ACC_W) begin : g_bad_acc_w
    $error("mac_seq_ctrl: ACC_W must be 32");
  end

  mac_state_e       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             relu_q, relu_d;

  logic [7:0]  act_lane_s [MAC_LANES];
  logic [7:0]  wgt_lane_s [MAC_LANES];
  logic [31:0] mac_sum_s;

  // Split the packed operand words into per-lane bytes for the datapath.
  always_comb begin
    for (int k = 0; k < MAC_LANES; k++) begin
      act_lane_s[k] = lane_slice(bus.op_act_i, k);
      wgt_lane_s[k] = lane_slice(bus.op_wgt_i, k);
    end
  end

  mac_8 u_mac_8 (
    .in_i      (act_lane_s),
    .weight_i  (wgt_lane_s),
    .sum_in_i  (acc_q),
    .sum_out_o (mac_sum_s)
  );

  // Next-state logic: command capture, beat accumulation, result handoff, flush override.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    relu_d  = relu_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          acc_d  = bus.cmd_acc_i;
          cnt_d  = bus.cmd_len_i;
          relu_d = bus.cmd_relu_i;
          if (bus.cmd_len_i == {LEN_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.op_valid_i) begin
          acc_d = mac_sum_s;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.res_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = 32'd0;
        cnt_d   = {LEN_W{1'b0}};
        relu_d  = 1'b0;
      end
    endcase
    // Abort wins over any handshake in the same cycle; in IDLE there is nothing to drop.
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      acc_d   = 32'd0;
      cnt_d   = {LEN_W{1'b0}};
    end else begin
      state_d = state_d;
    end
  end

  // State, accumulator, beat counter and ReLU flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= {LEN_W{1'b0}};
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      relu_q  <= relu_d;
    end
  end

  // Handshake and result outputs decoded purely from registered state, so they are stable within a cycle.
  always_comb begin
    bus.cmd_ready_o = 1'b0;
    bus.op_ready_o  = 1'b0;
    bus.res_valid_o = 1'b0;
    bus.res_data_o  = 32'd0;
    busy_o          = 1'b1;
    case (state_q)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        busy_o          = 1'b0;
      end
      RUN: begin
        bus.op_ready_o = 1'b1;
      end
      DONE: begin
        bus.res_valid_o = 1'b1;
        if (relu_q && acc_q[31]) begin
          bus.res_data_o = 32'd0;
        end else begin
          bus.res_data_o = acc_q;
        end
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq_ctrl_if #(.LEN_W(16)) bus ();

  mac_seq_ctrl #(.LEN_W(16), .ACC_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_len_i   = 16'd0;
    bus.cmd_acc_i   = 32'd0;
    bus.cmd_relu_i  = 1'b0;
    bus.op_valid_i  = 1'b0;
    bus.op_act_i    = 32'd0;
    bus.op_wgt_i    = 32'd0;
    bus.res_ready_i = 1'b0;
    flush           = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the command handshake.
  task automatic send_cmd(input logic [15:0] len, input logic [31:0] acc, input logic relu);
    int w = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_len_i   = len;
    bus.cmd_acc_i   = acc;
    bus.cmd_relu_i  = relu;
    while (!bus.cmd_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready_o);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the beat handshake.
  task automatic send_beat(input logic [31:0] act, input logic [31:0] wgt);
    int w = 0;
    bus.op_valid_i = 1'b1;
    bus.op_act_i   = act;
    bus.op_wgt_i   = wgt;
    while (!bus.op_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (bus.op_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL op_accept: op_ready=%b required 1", bus.op_ready_o);
    end
    @(negedge clk);
    bus.op_valid_i = 1'b0;
  endtask

  // Expects the result to be presented now; checks it, accepts it, checks the return to IDLE.
  task automatic take_result(input logic [31:0] exp, input string name);
    n_tests++;
    if (bus.res_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: res_valid=%b required 1", name, bus.res_valid_o);
    end
    n_tests++;
    if (bus.res_data_o !== exp) begin
      n_fail++;
      $display("FAIL %s_data: res_data=0x%08h required 0x%08h", name, bus.res_data_o, exp);
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    n_tests++;
    if (bus.res_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_to_idle: res_valid=%b cmd_ready=%b busy=%b required 0 1 0",
               name, bus.res_valid_o, bus.cmd_ready_o, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (bus.cmd_ready_o !== 1'b1 || bus.op_ready_o !== 1'b0 || bus.res_valid_o !== 1'b0 ||
        bus.res_data_o !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cmd_ready=%b op_ready=%b res_valid=%b res_data=0x%08h busy=%b required 1 0 0 0x00000000 0",
               name, bus.cmd_ready_o, bus.op_ready_o, bus.res_valid_o, bus.res_data_o, busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset_idle");
  endtask

  task automatic test_basic();
    // lanes: 4*1 + 3*1 + 2*1 + 1*1 = 10
    send_cmd(16'd1, 32'd0, 1'b0);
    send_beat(32'h01020304, 32'h01010101);
    take_result(32'd10, "basic");
  endtask

  task automatic test_extremes();
    // 255 * -128 = -32640 per lane, -130560 per beat, three beats on top of 100
    send_cmd(16'd3, 32'd100, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(32'hFFFFFFFF, 32'h80808080);
    take_result(32'hFFFA0664, "extremes");
  endtask

  task automatic test_relu();
    send_cmd(16'd3, 32'd100, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(32'hFFFFFFFF, 32'h80808080);
    take_result(32'd0, "relu_clamp");
    // len=0: result the cycle after the command is accepted, no clamping
    send_cmd(16'd0, 32'hFFFFFFFB, 1'b0);
    take_result(32'hFFFFFFFB, "len_zero");
  endtask

  task automatic test_stall();
    // beat: 64*-2 + 48*2 + 32*-1 + 16*1 = -48; four beats on 1000 -> 808
    send_cmd(16'd4, 32'd1000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h10203040, 32'h01FF02FE);
      if (i < 3) begin
        @(negedge clk);
        n_tests++;
        if (bus.op_ready_o !== 1'b1 || busy !== 1'b1 || bus.res_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_gap_%0d: op_ready=%b busy=%b res_valid=%b required 1 1 0",
                   i, bus.op_ready_o, busy, bus.res_valid_o);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd808) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: res_valid=%b res_data=0x%08h required 1 0x00000328",
                 c, bus.res_valid_o, bus.res_data_o);
      end
      @(negedge clk);
    end
    take_result(32'd808, "stall");
  endtask

  task automatic test_wrap();
    send_cmd(16'd1, 32'h7FFFFFFF, 1'b0);
    send_beat(32'h000000FF, 32'h00000001);
    take_result(32'h800000FE, "wrap");
  endtask

  task automatic test_abort_reset();
    send_cmd(16'd4, 32'd0, 1'b0);
    send_beat(32'h01010101, 32'h01010101);
    send_beat(32'h01010101, 32'h01010101);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // 7 + 10 = 17; old beats must not contribute
    send_cmd(16'd1, 32'd7, 1'b0);
    send_beat(32'h01020304, 32'h01010101);
    take_result(32'd17, "after_reset");
  endtask

  task automatic test_abort_flush();
    send_cmd(16'd4, 32'd0, 1'b0);
    send_beat(32'h01010101, 32'h01010101);
    send_beat(32'h01010101, 32'h01010101);
    // flush beats a simultaneous operand handshake
    flush          = 1'b1;
    bus.op_valid_i = 1'b1;
    bus.op_act_i   = 32'h01010101;
    bus.op_wgt_i   = 32'h01010101;
    @(negedge clk);
    flush          = 1'b0;
    bus.op_valid_i = 1'b0;
    check_reset_outputs("flush_state");
    // flush in IDLE changes nothing
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_reset_outputs("flush_idle_noop");
    send_cmd(16'd1, 32'd7, 1'b0);
    send_beat(32'h01020304, 32'h01010101);
    take_result(32'd17, "after_flush");
  endtask

  task automatic test_back_to_back();
    // two beats of 4*2 = 8 each -> 16
    send_cmd(16'd2, 32'd0, 1'b0);
    send_beat(32'h01010101, 32'h02020202);
    send_beat(32'h01010101, 32'h02020202);
    n_tests++;
    if (bus.cmd_ready_o !== 1'b0 || bus.op_ready_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ready: cmd_ready=%b op_ready=%b busy=%b required 0 0 1",
               bus.cmd_ready_o, bus.op_ready_o, busy);
    end
    n_tests++;
    if (bus.res_data_o !== 32'd16) begin
      n_fail++;
      $display("FAIL b2b_data: res_data=0x%08h required 0x00000010", bus.res_data_o);
    end
    // result accepted while a command is already waiting: it must not be taken in that cycle
    bus.res_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_len_i   = 16'd0;
    bus.cmd_acc_i   = 32'd55;
    bus.cmd_relu_i  = 1'b0;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_to_idle_no_cmd: busy=%b cmd_ready=%b required 0 1", busy, bus.cmd_ready_o);
    end
    // the waiting command is taken on the next edge
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    take_result(32'd55, "b2b_second");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_relu();
    test_stall();
    test_wrap();
    test_abort_reset();
    test_abort_flush();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
